reservation_station: RTL and testbench

//  Holds dispatched ALU-class instructions (ARITH, ARITHI, BR, JAL, JALR, LUI, AUIPC)

---
 rtl/reservation_station_pkg.sv | 66 ++++++
 rtl/rs_pick_lowest.sv | 22 ++
 rtl/reservation_station.sv | 165 ++++++++++++++++
 tb/tb_reservation_station.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/reservation_station_pkg.sv
// Shared constants and record types for the ALU reservation station.
// Operand snooping is shared between dispatch forwarding and wakeup.
package reservation_station_pkg;

  localparam int RS_SIZE       = 16;
  localparam int RS_IDX_WIDTH  = 4;
  localparam int ROB_POS_WIDTH = 4;

  localparam logic [6:0] OPC_ARITH  = 7'b0110011;
  localparam logic [6:0] OPC_ARITHI = 7'b0010011;
  localparam logic [6:0] OPC_BR     = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  typedef struct packed {
    logic [6:0]               opcode;
    logic [2:0]               funct3;
    logic                     funct7;
    logic [31:0]              val1;
    logic [31:0]              val2;
    logic [31:0]              imm;
    logic [31:0]              pc;
    logic [ROB_POS_WIDTH-1:0] rob_pos;
  } alu_cmd_t;

  typedef struct packed {
    alu_cmd_t                 cmd;
    logic                     has_dep1;
    logic [ROB_POS_WIDTH-1:0] dep1;
    logic                     has_dep2;
    logic [ROB_POS_WIDTH-1:0] dep2;
  } rs_entry_t;

  typedef struct packed {
    logic        pending;
    logic [31:0] val;
  } operand_t;

  // ALU broadcast is checked first so it wins an (illegal) same-tag tie.
  function automatic operand_t snoop_operand(
    input logic                     has_dep,
    input logic [ROB_POS_WIDTH-1:0] dep,
    input logic [31:0]              val,
    input logic                     a_en,
    input logic [ROB_POS_WIDTH-1:0] a_tag,
    input logic [31:0]              a_val,
    input logic                     l_en,
    input logic [ROB_POS_WIDTH-1:0] l_tag,
    input logic [31:0]              l_val
  );
    operand_t r;
    r.pending = has_dep;
    r.val     = val;
    if (has_dep && a_en && (a_tag == dep)) begin
      r.pending = 1'b0;
      r.val     = a_val;
    end else if (has_dep && l_en && (l_tag == dep)) begin
      r.pending = 1'b0;
      r.val     = l_val;
    end
    return r;
  endfunction

endpackage

// File: rtl/rs_pick_lowest.sv
// Priority encoder: reports whether any bit is set and the lowest set index.
module rs_pick_lowest #(
  parameter int N     = 16,
  parameter int IDX_W = 4
) (
  input  logic [N-1:0]     vec,
  output logic             found,
  output logic [IDX_W-1:0] idx
);

  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (vec[i]) begin
        found = 1'b1;
        idx   = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/reservation_station.sv
// ALU reservation station: holds dispatched ops until both operands are known,
// snoops ALU/LSB broadcasts, and issues the lowest-index ready entry each cycle.
module reservation_station
  import reservation_station_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rdy,
  input  logic                     rollback,
  input  logic                     issue_valid,
  input  logic [6:0]               issue_opcode,
  input  logic [2:0]               issue_funct3,
  input  logic                     issue_funct7,
  input  logic                     issue_has_dep1,
  input  logic [ROB_POS_WIDTH-1:0] issue_dep1,
  input  logic [31:0]              issue_val1,
  input  logic                     issue_has_dep2,
  input  logic [ROB_POS_WIDTH-1:0] issue_dep2,
  input  logic [31:0]              issue_val2,
  input  logic [31:0]              issue_imm,
  input  logic [31:0]              issue_pc,
  input  logic [ROB_POS_WIDTH-1:0] issue_rob_pos,
  output logic                     rs_full,
  output logic                     alu_en,
  output logic [6:0]               alu_opcode,
  output logic [2:0]               alu_funct3,
  output logic                     alu_funct7,
  output logic [31:0]              alu_val1,
  output logic [31:0]              alu_val2,
  output logic [31:0]              alu_imm,
  output logic [31:0]              alu_pc,
  output logic [ROB_POS_WIDTH-1:0] alu_rob_pos,
  input  logic                     alu_result,
  input  logic [ROB_POS_WIDTH-1:0] alu_result_rob_pos,
  input  logic [31:0]              alu_result_val,
  input  logic                     lsb_result,
  input  logic [ROB_POS_WIDTH-1:0] lsb_result_rob_pos,
  input  logic [31:0]              lsb_result_val
);

  logic [RS_SIZE-1:0]      busy_q, busy_d;
  rs_entry_t               ent_q [RS_SIZE];
  rs_entry_t               ent_d [RS_SIZE];
  logic                    rs_full_q, rs_full_d;
  logic                    alu_en_q, alu_en_d;
  alu_cmd_t                alu_cmd_q, alu_cmd_d;

  logic [RS_SIZE-1:0]      ready_vec;
  logic [RS_SIZE-1:0]      free_vec;
  logic                    free_found, rdy_found;
  logic [RS_IDX_WIDTH-1:0] free_idx, rdy_idx;
  operand_t                wk1, wk2, fw1, fw2;
  rs_entry_t               new_ent;

  always_comb begin
    for (int i = 0; i < RS_SIZE; i++) begin
      ready_vec[i] = busy_q[i] & ~ent_q[i].has_dep1 & ~ent_q[i].has_dep2;
    end
  end

  assign free_vec = ~busy_q;

  rs_pick_lowest #(.N(RS_SIZE), .IDX_W(RS_IDX_WIDTH)) u_pick_free (
    .vec   (free_vec),
    .found (free_found),
    .idx   (free_idx)
  );

  rs_pick_lowest #(.N(RS_SIZE), .IDX_W(RS_IDX_WIDTH)) u_pick_ready (
    .vec   (ready_vec),
    .found (rdy_found),
    .idx   (rdy_idx)
  );

  // Incoming instruction, with same-cycle broadcast forwarding applied.
  always_comb begin
    fw1 = snoop_operand(issue_has_dep1, issue_dep1, issue_val1,
                        alu_result, alu_result_rob_pos, alu_result_val,
                        lsb_result, lsb_result_rob_pos, lsb_result_val);
    fw2 = snoop_operand(issue_has_dep2, issue_dep2, issue_val2,
                        alu_result, alu_result_rob_pos, alu_result_val,
                        lsb_result, lsb_result_rob_pos, lsb_result_val);
    new_ent.cmd.opcode  = issue_opcode;
    new_ent.cmd.funct3  = issue_funct3;
    new_ent.cmd.funct7  = issue_funct7;
    new_ent.cmd.val1    = fw1.val;
    new_ent.cmd.val2    = fw2.val;
    new_ent.cmd.imm     = issue_imm;
    new_ent.cmd.pc      = issue_pc;
    new_ent.cmd.rob_pos = issue_rob_pos;
    new_ent.has_dep1    = fw1.pending;
    new_ent.dep1        = issue_dep1;
    new_ent.has_dep2    = fw2.pending;
    new_ent.dep2        = issue_dep2;
  end

  always_comb begin
    ent_d     = ent_q;
    busy_d    = busy_q;
    rs_full_d = rs_full_q;
    alu_en_d  = alu_en_q;
    alu_cmd_d = alu_cmd_q;
    wk1       = '0;
    wk2       = '0;
    if (rdy) begin
      for (int i = 0; i < RS_SIZE; i++) begin
        if (busy_q[i]) begin
          wk1 = snoop_operand(ent_q[i].has_dep1, ent_q[i].dep1, ent_q[i].cmd.val1,
                              alu_result, alu_result_rob_pos, alu_result_val,
                              lsb_result, lsb_result_rob_pos, lsb_result_val);
          wk2 = snoop_operand(ent_q[i].has_dep2, ent_q[i].dep2, ent_q[i].cmd.val2,
                              alu_result, alu_result_rob_pos, alu_result_val,
                              lsb_result, lsb_result_rob_pos, lsb_result_val);
          ent_d[i].has_dep1 = wk1.pending;
          ent_d[i].cmd.val1 = wk1.val;
          ent_d[i].has_dep2 = wk2.pending;
          ent_d[i].cmd.val2 = wk2.val;
        end
      end
      // Issue reads pre-edge state; a ready entry has no pending operand to update.
      alu_en_d = rdy_found;
      if (rdy_found) begin
        busy_d[rdy_idx] = 1'b0;
        alu_cmd_d       = ent_q[rdy_idx].cmd;
      end
      // A free slot is never busy, so it cannot collide with the issuing slot.
      if (issue_valid && free_found) begin
        busy_d[free_idx] = 1'b1;
        ent_d[free_idx]  = new_ent;
      end
      rs_full_d = &busy_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || rollback) begin
      busy_q    <= '0;
      rs_full_q <= 1'b0;
      alu_en_q  <= 1'b0;
      alu_cmd_q <= '0;
    end else begin
      busy_q    <= busy_d;
      rs_full_q <= rs_full_d;
      alu_en_q  <= alu_en_d;
      alu_cmd_q <= alu_cmd_d;
    end
  end

  // Entry payload is only meaningful while busy, so it carries no reset.
  always_ff @(posedge clk) begin
    ent_q <= ent_d;
  end

  assign rs_full     = rs_full_q;
  assign alu_en      = alu_en_q;
  assign alu_opcode  = alu_cmd_q.opcode;
  assign alu_funct3  = alu_cmd_q.funct3;
  assign alu_funct7  = alu_cmd_q.funct7;
  assign alu_val1    = alu_cmd_q.val1;
  assign alu_val2    = alu_cmd_q.val2;
  assign alu_imm     = alu_cmd_q.imm;
  assign alu_pc      = alu_cmd_q.pc;
  assign alu_rob_pos = alu_cmd_q.rob_pos;

endmodule

// File: tb/tb_reservation_station.sv
// Scoreboard bench for reservation_station: a slot-list model predicts each
// issued command into a queue; a monitor pops and compares on alu_en.
module tb_reservation_station;
  import reservation_station_pkg::*;

  logic        clk = 1'b0;
  logic        rst, rdy, rollback, issue_valid;
  logic [6:0]  issue_opcode;
  logic [2:0]  issue_funct3;
  logic        issue_funct7, issue_has_dep1, issue_has_dep2;
  logic [3:0]  issue_dep1, issue_dep2, issue_rob_pos;
  logic [31:0] issue_val1, issue_val2, issue_imm, issue_pc;
  logic        rs_full, alu_en, alu_funct7;
  logic [6:0]  alu_opcode;
  logic [2:0]  alu_funct3;
  logic [31:0] alu_val1, alu_val2, alu_imm, alu_pc;
  logic [3:0]  alu_rob_pos;
  logic        alu_result, lsb_result;
  logic [3:0]  alu_result_rob_pos, lsb_result_rob_pos;
  logic [31:0] alu_result_val, lsb_result_val;

  reservation_station dut (
    .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback),
    .issue_valid(issue_valid), .issue_opcode(issue_opcode), .issue_funct3(issue_funct3),
    .issue_funct7(issue_funct7), .issue_has_dep1(issue_has_dep1), .issue_dep1(issue_dep1),
    .issue_val1(issue_val1), .issue_has_dep2(issue_has_dep2), .issue_dep2(issue_dep2),
    .issue_val2(issue_val2), .issue_imm(issue_imm), .issue_pc(issue_pc),
    .issue_rob_pos(issue_rob_pos), .rs_full(rs_full), .alu_en(alu_en),
    .alu_opcode(alu_opcode), .alu_funct3(alu_funct3), .alu_funct7(alu_funct7),
    .alu_val1(alu_val1), .alu_val2(alu_val2), .alu_imm(alu_imm), .alu_pc(alu_pc),
    .alu_rob_pos(alu_rob_pos), .alu_result(alu_result), .alu_result_rob_pos(alu_result_rob_pos),
    .alu_result_val(alu_result_val), .lsb_result(lsb_result),
    .lsb_result_rob_pos(lsb_result_rob_pos), .lsb_result_val(lsb_result_val)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        f7;
    logic [31:0] v1, v2, imm, pc;
    logic [3:0]  rob;
  } cmd_t;

  typedef struct {
    bit          valid;
    bit          p1, p2;
    logic [3:0]  t1, t2;
    cmd_t        c;
  } mslot_t;

  mslot_t m [16];
  cmd_t   exp_q [$];
  cmd_t   hold_cmd = '0;
  bit     exp_en   = 1'b0;
  bit     exp_full = 1'b0;
  int     vectors  = 0;
  int     errors   = 0;

  task automatic chk(input string name, input logic [142:0] got, input logic [142:0] want);
    vectors++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, want, $time);
    end
  endtask

  // A pending operand becomes known when either broadcast carries its tag.
  task automatic wake(inout bit p, inout logic [31:0] v, input logic [3:0] t);
    if (p && alu_result && alu_result_rob_pos == t) begin
      p = 0; v = alu_result_val;
    end else if (p && lsb_result && lsb_result_rob_pos == t) begin
      p = 0; v = lsb_result_val;
    end
  endtask

  task automatic model_step();
    int ri, fi, cnt;
    mslot_t n;
    if (rst || rollback) begin
      foreach (m[i]) m[i].valid = 0;
      exp_en = 0; exp_full = 0; hold_cmd = '0;
      return;
    end
    if (!rdy) begin
      if (exp_en) exp_q.push_back(hold_cmd);
      return;
    end
    ri = -1; fi = -1;
    for (int i = 0; i < 16; i++) begin
      if (ri < 0 && m[i].valid && !m[i].p1 && !m[i].p2) ri = i;
      if (fi < 0 && !m[i].valid) fi = i;
    end
    for (int i = 0; i < 16; i++) begin
      if (m[i].valid) begin
        wake(m[i].p1, m[i].c.v1, m[i].t1);
        wake(m[i].p2, m[i].c.v2, m[i].t2);
      end
    end
    if (ri >= 0) begin
      m[ri].valid = 0;
      exp_en = 1; hold_cmd = m[ri].c;
      exp_q.push_back(m[ri].c);
    end else begin
      exp_en = 0;
    end
    if (issue_valid && fi >= 0) begin
      n.valid = 1;
      n.p1 = issue_has_dep1; n.t1 = issue_dep1;
      n.p2 = issue_has_dep2; n.t2 = issue_dep2;
      n.c = '{op: issue_opcode, f3: issue_funct3, f7: issue_funct7, v1: issue_val1,
              v2: issue_val2, imm: issue_imm, pc: issue_pc, rob: issue_rob_pos};
      wake(n.p1, n.c.v1, n.t1);
      wake(n.p2, n.c.v2, n.t2);
      m[fi] = n;
    end
    cnt = 0;
    foreach (m[i]) if (m[i].valid) cnt++;
    exp_full = (cnt == 16);
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    issue_valid = 0; alu_result = 0; lsb_result = 0;
  endtask

  task automatic disp(input logic [6:0] op, input logic hd1, input logic [3:0] d1,
                      input logic [31:0] v1, input logic hd2, input logic [3:0] d2,
                      input logic [31:0] v2, input logic [31:0] imm, input logic [3:0] rob);
    issue_valid = 1; issue_opcode = op; issue_funct3 = rob[2:0]; issue_funct7 = rob[0];
    issue_has_dep1 = hd1; issue_dep1 = d1; issue_val1 = v1;
    issue_has_dep2 = hd2; issue_dep2 = d2; issue_val2 = v2;
    issue_imm = imm; issue_pc = 32'h1000 + 32'(rob) * 4; issue_rob_pos = rob;
  endtask

  // Monitor: every cycle check control outputs; on alu_en pop the predicted command.
  initial begin
    cmd_t got, want;
    forever begin
      @(posedge clk); #1;
      got = '{op: alu_opcode, f3: alu_funct3, f7: alu_funct7, v1: alu_val1, v2: alu_val2,
              imm: alu_imm, pc: alu_pc, rob: alu_rob_pos};
      chk("alu_en", 143'(alu_en), 143'(exp_en));
      chk("rs_full", 143'(rs_full), 143'(exp_full));
      if (alu_en === 1'b1) begin
        if (exp_q.size() == 0) begin
          vectors++; errors++;
          $display("FAIL unexpected_issue: got %h expected none at %0t", got, $time);
        end else begin
          want = exp_q.pop_front();
          chk("alu_cmd", got, want);
        end
      end else begin
        chk("alu_hold", got, hold_cmd);
      end
    end
  end

  initial begin
    logic [3:0] at, lt;
    rst = 1; rdy = 1; rollback = 0;
    disp(OPC_ARITH, 0, 0, 0, 0, 0, 0, 0, 0);
    idle();
    tick(); tick();
    rst = 0;
    tick();

    // ADDI with operands ready
    disp(OPC_ARITHI, 0, 0, 32'd5, 0, 0, 0, 32'd3, 4'd1); tick();
    idle(); tick(); tick();

    // ADD waiting on tag 2, woken by ALU broadcast
    disp(OPC_ARITH, 1, 4'd2, 0, 0, 0, 32'd7, 0, 4'd3); tick();
    idle(); tick(); tick();
    alu_result = 1; alu_result_rob_pos = 4'd2; alu_result_val = 32'h10; tick();
    idle(); tick(); tick();

    // dispatch-cycle forwarding from LSB
    disp(OPC_BR, 1, 4'd7, 0, 0, 0, 32'd1, 32'hfffffff0, 4'd4);
    lsb_result = 1; lsb_result_rob_pos = 4'd7; lsb_result_val = 32'd9; tick();
    idle(); tick(); tick();

    // fill all 16 entries blocked on tag 5, then release
    for (int i = 0; i < 16; i++) begin
      disp(OPC_ARITH, 1, 4'd5, 0, 0, 0, 32'(i), 32'(i * 3), 4'(i)); tick();
    end
    disp(OPC_LUI, 0, 0, 32'hdead, 0, 0, 0, 0, 4'd9); tick();
    idle(); tick();
    alu_result = 1; alu_result_rob_pos = 4'd5; alu_result_val = 32'h55; tick();
    idle();
    repeat (18) tick();

    // rollback discards pending entries
    for (int i = 0; i < 3; i++) begin
      disp(OPC_JALR, 1, 4'd6, 0, 0, 0, 0, 32'd8, 4'(i + 10)); tick();
    end
    idle(); rollback = 1; tick();
    rollback = 0; alu_result = 1; alu_result_rob_pos = 4'd6; alu_result_val = 32'h66; tick();
    idle(); disp(OPC_AUIPC, 0, 0, 0, 0, 0, 0, 32'h2000, 4'd13); tick();
    idle(); repeat (3) tick();

    // freeze with a ready entry and a broadcast outstanding
    disp(OPC_ARITH, 1, 4'd8, 0, 0, 0, 32'd2, 0, 4'd14); tick();
    disp(OPC_JAL, 0, 0, 32'd11, 0, 0, 0, 32'd4, 4'd15); tick();
    idle(); rdy = 0;
    alu_result = 1; alu_result_rob_pos = 4'd8; alu_result_val = 32'h88;
    repeat (3) tick();
    idle(); rdy = 1; tick();
    alu_result = 1; alu_result_rob_pos = 4'd8; alu_result_val = 32'h88; tick();
    idle(); repeat (3) tick();

    // randomized traffic
    for (int c = 0; c < 2000; c++) begin
      idle();
      if ($urandom_range(99) < 60)
        disp(7'($urandom_range(1) ? OPC_ARITH : OPC_ARITHI), 1'($urandom_range(1)),
             4'($urandom_range(7)), $urandom, 1'($urandom_range(1)), 4'($urandom_range(7)),
             $urandom, $urandom, 4'($urandom));
      at = 4'($urandom_range(7)); lt = 4'($urandom_range(7));
      alu_result = ($urandom_range(99) < 40); alu_result_rob_pos = at; alu_result_val = $urandom;
      lsb_result = ($urandom_range(99) < 30) && !(alu_result && lt == at);
      lsb_result_rob_pos = lt; lsb_result_val = $urandom;
      rdy = ($urandom_range(99) < 90);
      rollback = ($urandom_range(999) < 15);
      tick();
    end
    rdy = 1; rollback = 0;

    // drain: broadcast every tag, then let the rest issue
    for (int t = 0; t < 16; t++) begin
      idle(); alu_result = 1; alu_result_rob_pos = 4'(t); alu_result_val = 32'(t); tick();
    end
    idle();
    repeat (20) tick();
    chk("drained", 143'(exp_q.size()), 143'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
